axi_multi_ch_logger: RTL and testbench
======================================

// Module: axi_multi_ch_logger
// PURPOSE
//  Multi-channel AXI address-phase logger; successor of the single-channel BRAM logger.
//  Snoops NUM_CH address channels (e.g. AR+AW of several ports) and records one entry per handshake
//  {ch, len, id, addr, timestamp} into an internal DEPTH x ENTRY_BITW RAM. Adds arbitration, drop
//  counting, stop-on-full/ring modes and a 1-cycle host read port. Sits beside the RAB on the debug path.
// PARAMETERS
//  NUM_CH          2     snooped channels (>=1); CH_BITW = max(1,$clog2(NUM_CH))
//  AXI_ADDR_BITW   32    address width
//  AXI_ID_BITW     8     ID width
//  AXI_LEN_BITW    8     burst length width
//  TIMESTAMP_BITW  32    timestamp width
//  DEPTH           4096  entries (power of 2, >=4); PTR_BITW=$clog2(DEPTH), CNT_BITW=$clog2(DEPTH+1)
//  AFULL_MARGIN    1024  AlmostFull_SO threshold below DEPTH (< DEPTH)
//  DROP_CNT_BITW   16    width of saturating drop counter
//  ENTRY_BITW = CH_BITW+AXI_LEN_BITW+AXI_ID_BITW+AXI_ADDR_BITW+TIMESTAMP_BITW (derived, localparam)
// PORTS
//  Clk_CI        in   1                    clock
//  Rst_RBI       in   1                    reset, asynchronous, active-low
//  AxiValid_SI   in   NUM_CH               per-channel valid (snooped)
//  AxiReady_SI   in   NUM_CH               per-channel ready (snooped)
//  AxiId_DI      in   NUM_CH*AXI_ID_BITW   per-channel ID, ch c at [c*AXI_ID_BITW +: AXI_ID_BITW]
//  AxiAddr_DI    in   NUM_CH*AXI_ADDR_BITW per-channel address, same packing
//  AxiLen_DI     in   NUM_CH*AXI_LEN_BITW  per-channel length, same packing
//  Mode_SI       in   1                    0 = stop-on-full, 1 = ring (wrap)
//  Clear_SI      in   1                    request full clear
//  Clearing_SO   out  1                    high in CLEARING
//  AlmostFull_SO out  1                    stop mode only: WrCnt_DO >= DEPTH-AFULL_MARGIN
//  Full_SO       out  1                    high in FULL
//  Wrapped_SO    out  1                    ring mode: sticky, write pointer has wrapped
//  WrCnt_DO      out  CNT_BITW             valid entries (saturates at DEPTH)
//  DropCnt_DO    out  DROP_CNT_BITW        lost events, saturating
//  RdEn_SI       in   1                    host read enable
//  RdAddr_DI     in   PTR_BITW             host read entry index
//  RdData_DO     out  ENTRY_BITW           entry, valid 1 cycle after RdEn_SI; holds otherwise
// BEHAVIOUR
//  Reset: State=CLEARING, ptr/WrCnt/DropCnt/timestamp/Wrapped/pending/rr=0, RdData_DO=0,
//   Clearing_SO=1, other outputs 0. RAM is wiped after every reset.
//  Capture: handshake (Valid&Ready) on ch c at edge E0 loads pending reg c with fields + current timestamp.
//   If pending c is occupied and not granted that cycle -> event dropped, DropCnt+1 (sat).
//   Granted pending reg may be reloaded on the same edge.
//  Arbiter: round-robin over occupied pending regs, search starts at last-granted+1 (initial ch0 first).
//   One RAM write per cycle at ptr; entry written at E1 = 1 cycle after capture minimum.
//  Entry layout LSB->MSB: timestamp, addr, id, len, ch.
//  States:
//   CLEARING: write 0 at ptr, ptr+1 per cycle; captures dropped+counted; pending regs flushed.
//    ptr==DEPTH-1 -> READY, ptr=0, WrCnt=0, Wrapped=0, latch Mode_SI. Clear_SI here restarts at ptr 0.
//   READY: grant writes; ptr+1 (mod DEPTH); WrCnt+1 (sat DEPTH).
//    Stop mode: write that makes WrCnt==DEPTH -> FULL. Ring mode: wrap sets Wrapped, never FULL.
//    Clear_SI -> CLEARING, ptr=0, DropCnt=0 (Clear wins over same-cycle write).
//   FULL: no writes; captures dropped+counted; Clear_SI -> CLEARING.
//  Timestamp: +1 per cycle, wraps at all-ones; held 0 in CLEARING and cycle of Clear_SI.
//  Host read: any state; reading an entry written the same cycle returns old data.
//  Mode_SI only takes effect when latched at CLEARING->READY.
// CONFIGURATION
//  AXI_LOGGER_ID_FILTER_EN defined: extra ports FiltId_DI, FiltMask_DI (in, AXI_ID_BITW, shared);
//   handshake is logged only if (AxiId & FiltMask)==(FiltId & FiltMask); filtered events are neither
//   captured nor counted as drops.
//  Undefined: ports absent, every handshake is logged.
// TESTING (DEPTH=16, AFULL_MARGIN=4, NUM_CH=2)
//  Reset release -> Clearing_SO high 16 cycles, then 0; WrCnt=0; reads of idx 0..15 return 0.
//  ch0 id=0x05 addr=0x1000_0040 len=3 at ts T -> 2 cycles later WrCnt=1; idx0 = {0,3,0x05,0x1000_0040,T}.
//  ch0+ch1 handshake same cycle -> idx0 ch=0, idx1 ch=1, consecutive writes, same timestamp, DropCnt=0.
//  Both channels handshake 3 consecutive cycles -> 4 entries (ch0,ch1,ch0,ch1), DropCnt=2.
//  Stop mode, 17 spaced handshakes -> AlmostFull at WrCnt=12, Full at 16, DropCnt=1; Clear_SI -> 16 clear cycles.
//  Ring mode, 20 spaced handshakes -> WrCnt=16, Wrapped=1, Full=0; idx0..3 hold events 17..20.

Source files
------------

// File: rtl/axi_multi_ch_logger.sv
// Multi-channel AXI address-phase logger: one RAM entry {ch,len,id,addr,ts} per snooped handshake.
// Optional shared ID/mask capture filter enabled by defining AXI_LOGGER_ID_FILTER_EN.
module axi_multi_ch_logger #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned AXI_ADDR_BITW  = 32,
    parameter int unsigned AXI_ID_BITW    = 8,
    parameter int unsigned AXI_LEN_BITW   = 8,
    parameter int unsigned TIMESTAMP_BITW = 32,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned AFULL_MARGIN   = 1024,
    parameter int unsigned DROP_CNT_BITW  = 16,
    localparam int unsigned CH_BITW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned PTR_BITW      = $clog2(DEPTH),
    localparam int unsigned CNT_BITW      = $clog2(DEPTH + 1),
    localparam int unsigned ENTRY_BITW    = CH_BITW + AXI_LEN_BITW + AXI_ID_BITW
                                            + AXI_ADDR_BITW + TIMESTAMP_BITW
) (
    input  logic                            Clk_CI,
    input  logic                            Rst_RBI,
    input  logic [NUM_CH-1:0]               AxiValid_SI,
    input  logic [NUM_CH-1:0]               AxiReady_SI,
    input  logic [NUM_CH*AXI_ID_BITW-1:0]   AxiId_DI,
    input  logic [NUM_CH*AXI_ADDR_BITW-1:0] AxiAddr_DI,
    input  logic [NUM_CH*AXI_LEN_BITW-1:0]  AxiLen_DI,
    input  logic                            Mode_SI,
    input  logic                            Clear_SI,
`ifdef AXI_LOGGER_ID_FILTER_EN
    input  logic [AXI_ID_BITW-1:0]          FiltId_DI,
    input  logic [AXI_ID_BITW-1:0]          FiltMask_DI,
`endif
    output logic                            Clearing_SO,
    output logic                            AlmostFull_SO,
    output logic                            Full_SO,
    output logic                            Wrapped_SO,
    output logic [CNT_BITW-1:0]             WrCnt_DO,
    output logic [DROP_CNT_BITW-1:0]        DropCnt_DO,
    input  logic                            RdEn_SI,
    input  logic [PTR_BITW-1:0]             RdAddr_DI,
    output logic [ENTRY_BITW-1:0]           RdData_DO
);

    typedef struct packed {
        logic [CH_BITW-1:0]        ch;
        logic [AXI_LEN_BITW-1:0]   len;
        logic [AXI_ID_BITW-1:0]    id;
        logic [AXI_ADDR_BITW-1:0]  addr;
        logic [TIMESTAMP_BITW-1:0] ts;
    } entry_t;

    typedef enum logic [1:0] {
        ST_CLEARING = 2'd0,
        ST_READY    = 2'd1,
        ST_FULL     = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [PTR_BITW-1:0]       ptr_q, ptr_d;
    logic [CNT_BITW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [DROP_CNT_BITW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [TIMESTAMP_BITW-1:0] ts_q, ts_d;
    logic                      wrapped_q, wrapped_d;
    logic                      mode_q, mode_d;
    logic [CH_BITW-1:0]        rr_q, rr_d;
    logic [NUM_CH-1:0]         pend_vld_q, pend_vld_d;
    entry_t                    pend_q [NUM_CH];
    entry_t                    pend_d [NUM_CH];
    logic                      clearing_q, almost_full_q, full_q;
    logic [ENTRY_BITW-1:0]     rd_data_q;

    entry_t                    mem_q [DEPTH];
    logic                      mem_we;
    entry_t                    mem_wdata;

    logic [NUM_CH-1:0]         filt_pass;
    logic [NUM_CH-1:0]         cap;
    logic [NUM_CH-1:0]         drop;
    logic [NUM_CH-1:0]         grant_oh;
    logic                      arb_found;
    logic [CH_BITW-1:0]        arb_idx;
    entry_t                    cap_e;

`ifdef AXI_LOGGER_ID_FILTER_EN
    always_comb begin
        filt_pass = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            filt_pass[c] = ((AxiId_DI[c*AXI_ID_BITW +: AXI_ID_BITW] & FiltMask_DI)
                            == (FiltId_DI & FiltMask_DI));
        end
    end
`else
    assign filt_pass = '1;
`endif

    assign cap = AxiValid_SI & AxiReady_SI & filt_pass;

    // Round-robin: search starts at rr_q, which points one past the last grant
    always_comb begin
        grant_oh  = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            arb_idx = CH_BITW'((int'(rr_q) + i) % int'(NUM_CH));
            if (!arb_found && pend_vld_q[arb_idx]) begin
                grant_oh[arb_idx] = 1'b1;
                arb_found         = 1'b1;
            end
        end
    end

    // Next-state, RAM write and capture/drop decisions
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_cnt_d   = wr_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ts_d       = ts_q + TIMESTAMP_BITW'(1);
        wrapped_d  = wrapped_q;
        mode_d     = mode_q;
        rr_d       = rr_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        drop       = '0;
        cap_e      = '0;

        case (state_q)
            ST_CLEARING: begin
                mem_we     = 1'b1;
                ptr_d      = ptr_q + PTR_BITW'(1);
                ts_d       = '0;
                pend_vld_d = '0;
                drop       = cap;
                if (Clear_SI) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_BITW'(DEPTH - 1)) begin
                    state_d   = ST_READY;
                    ptr_d     = '0;
                    wr_cnt_d  = '0;
                    wrapped_d = 1'b0;
                    mode_d    = Mode_SI;
                end
            end
            ST_READY: begin
                if (Clear_SI) begin
                    state_d    = ST_CLEARING;
                    ptr_d      = '0;
                    ts_d       = '0;
                    pend_vld_d = '0;
                end else begin
                    if (arb_found) begin
                        mem_we = 1'b1;
                        ptr_d  = ptr_q + PTR_BITW'(1);
                        if (wr_cnt_q != CNT_BITW'(DEPTH)) begin
                            wr_cnt_d = wr_cnt_q + CNT_BITW'(1);
                        end
                        if (mode_q && (ptr_q == PTR_BITW'(DEPTH - 1))) begin
                            wrapped_d = 1'b1;
                        end
                        if (!mode_q && (wr_cnt_q == CNT_BITW'(DEPTH - 1))) begin
                            state_d = ST_FULL;
                        end
                        for (int c = 0; c < int'(NUM_CH); c++) begin
                            if (grant_oh[c]) begin
                                mem_wdata     = pend_q[c];
                                pend_vld_d[c] = 1'b0;
                                rr_d          = (c == int'(NUM_CH) - 1) ? '0 : CH_BITW'(c + 1);
                            end
                        end
                    end
                    // A granted slot frees up this edge, so it may be reloaded immediately
                    for (int c = 0; c < int'(NUM_CH); c++) begin
                        if (cap[c]) begin
                            if (pend_vld_q[c] && !grant_oh[c]) begin
                                drop[c] = 1'b1;
                            end else begin
                                cap_e.ch      = CH_BITW'(c);
                                cap_e.len     = AxiLen_DI[c*AXI_LEN_BITW +: AXI_LEN_BITW];
                                cap_e.id      = AxiId_DI[c*AXI_ID_BITW +: AXI_ID_BITW];
                                cap_e.addr    = AxiAddr_DI[c*AXI_ADDR_BITW +: AXI_ADDR_BITW];
                                cap_e.ts      = ts_q;
                                pend_d[c]     = cap_e;
                                pend_vld_d[c] = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_FULL: begin
                drop = cap;
                if (Clear_SI) begin
                    state_d    = ST_CLEARING;
                    ptr_d      = '0;
                    ts_d       = '0;
                    pend_vld_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEARING;
                ptr_d   = '0;
            end
        endcase

        if (Clear_SI) begin
            drop_cnt_d = '0;
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (drop[c] && (drop_cnt_d != '1)) begin
                    drop_cnt_d = drop_cnt_d + DROP_CNT_BITW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q       <= ST_CLEARING;
            ptr_q         <= '0;
            wr_cnt_q      <= '0;
            drop_cnt_q    <= '0;
            ts_q          <= '0;
            wrapped_q     <= 1'b0;
            mode_q        <= 1'b0;
            rr_q          <= '0;
            pend_vld_q    <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                pend_q[c] <= '0;
            end
            clearing_q    <= 1'b1;
            almost_full_q <= 1'b0;
            full_q        <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wr_cnt_q      <= wr_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            ts_q          <= ts_d;
            wrapped_q     <= wrapped_d;
            mode_q        <= mode_d;
            rr_q          <= rr_d;
            pend_vld_q    <= pend_vld_d;
            pend_q        <= pend_d;
            clearing_q    <= (state_d == ST_CLEARING);
            almost_full_q <= !mode_d && (wr_cnt_d >= CNT_BITW'(DEPTH - AFULL_MARGIN));
            full_q        <= (state_d == ST_FULL);
            if (RdEn_SI) begin
                rd_data_q <= mem_q[RdAddr_DI];
            end
        end
    end

    // Log RAM, no reset: contents are wiped by the CLEARING sweep
    always_ff @(posedge Clk_CI) begin
        if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    assign Clearing_SO   = clearing_q;
    assign AlmostFull_SO = almost_full_q;
    assign Full_SO       = full_q;
    assign Wrapped_SO    = wrapped_q;
    assign WrCnt_DO      = wr_cnt_q;
    assign DropCnt_DO    = drop_cnt_q;
    assign RdData_DO     = rd_data_q;

endmodule

// File: tb/tb_axi_multi_ch_logger.sv
// Directed bench for axi_multi_ch_logger (DEPTH=16, AFULL_MARGIN=4, NUM_CH=2), default build.
module tb_axi_multi_ch_logger;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AFM     = 4;
    localparam int unsigned CH_W    = 1;
    localparam int unsigned PTR_W   = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TS_W    = 32;
    localparam int unsigned ENTRY_W = 1 + 8 + 8 + 32 + 32;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  r;
        logic [7:0]  id0;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [7:0]  id1;
        logic [31:0] a1;
        logic [7:0]  l1;
        int          n;
        int          first;
        int          exp_wr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        valid = '0;
    logic [1:0]        ready = '0;
    logic [15:0]       id_bus = '0;
    logic [63:0]       addr_bus = '0;
    logic [15:0]       len_bus = '0;
    logic              mode = 1'b0;
    logic              clear = 1'b0;
    logic              rd_en = 1'b0;
    logic [PTR_W-1:0]  rd_addr = '0;
    logic              clearing, afull, full, wrapped;
    logic [CNT_W-1:0]  wr_cnt;
    logic [15:0]       drop_cnt;
    entry_t            rd_data;

    int                checks = 0;
    int                failures = 0;
    int unsigned       tb_ts = 0;
    entry_t            d;
    entry_t            exp_e;
    int unsigned       t0;
    int                widx;
    int                ch;
    int unsigned       ts_ev [21];
    vec_t              vecs [8];

    axi_multi_ch_logger #(
        .NUM_CH         (NUM_CH),
        .AXI_ADDR_BITW  (32),
        .AXI_ID_BITW    (8),
        .AXI_LEN_BITW   (8),
        .TIMESTAMP_BITW (TS_W),
        .DEPTH          (DEPTH),
        .AFULL_MARGIN   (AFM),
        .DROP_CNT_BITW  (16)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .AxiValid_SI   (valid),
        .AxiReady_SI   (ready),
        .AxiId_DI      (id_bus),
        .AxiAddr_DI    (addr_bus),
        .AxiLen_DI     (len_bus),
        .Mode_SI       (mode),
        .Clear_SI      (clear),
        .Clearing_SO   (clearing),
        .AlmostFull_SO (afull),
        .Full_SO       (full),
        .Wrapped_SO    (wrapped),
        .WrCnt_DO      (wr_cnt),
        .DropCnt_DO    (drop_cnt),
        .RdEn_SI       (rd_en),
        .RdAddr_DI     (rd_addr),
        .RdData_DO     (rd_data)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input int c, input logic [7:0] len, input logic [7:0] id,
                                  input logic [31:0] addr, input int unsigned ts);
        return {CH_W'(c), len, id, addr, TS_W'(ts)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    task automatic wait_clear_done(input string name);
        int n;
        n = 0;
        forever begin
            step();
            n++;
            if (!clearing || n >= 100) break;
        end
        chk(name, 128'(n), 128'(16));
        tb_ts = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid = '0;
        ready = '0;
        clear = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clearing", 128'(clearing), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_afull", 128'(afull), 128'(0));
        chk("rst_wrapped", 128'(wrapped), 128'(0));
        chk("rst_wrcnt", 128'(wr_cnt), 128'(0));
        chk("rst_dropcnt", 128'(drop_cnt), 128'(0));
        chk("rst_rddata", 128'(rd_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear_done("rst_clear_len");
    endtask

    task automatic rd(input int idx, output entry_t data);
        rd_en   = 1'b1;
        rd_addr = PTR_W'(idx);
        step();
        data    = rd_data;
        rd_en   = 1'b0;
    endtask

    task automatic hs_ch0(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        id_bus   = {8'h00, id};
        addr_bus = {32'h0, addr};
        len_bus  = {8'h00, len};
        valid    = 2'b01;
        ready    = 2'b01;
        step();
        valid    = '0;
        ready    = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b11, 2'b11, 8'h11, 32'h2000_0000, 8'h00, 8'h22, 32'h3000_0004, 8'h07, 2, 0, 2};
        vecs[1] = '{2'b10, 2'b10, 8'h00, 32'h0000_0000, 8'h00, 8'h33, 32'h3000_0100, 8'h0F, 1, 1, 3};
        vecs[2] = '{2'b01, 2'b01, 8'h44, 32'h2000_0FFC, 8'hFF, 8'h00, 32'h0000_0000, 8'h00, 1, 0, 4};
        vecs[3] = '{2'b11, 2'b11, 8'h55, 32'h2000_1000, 8'h01, 8'h66, 32'h3FFF_FFFC, 8'h02, 2, 1, 6};
        vecs[4] = '{2'b11, 2'b01, 8'h77, 32'h2000_2000, 8'h03, 8'h88, 32'h3000_2000, 8'h04, 1, 0, 7};
        vecs[5] = '{2'b10, 2'b11, 8'h99, 32'h2000_3000, 8'h05, 8'hAA, 32'h3000_3000, 8'h06, 1, 1, 8};
        vecs[6] = '{2'b11, 2'b11, 8'hBB, 32'hFFFF_FFFF, 8'h80, 8'hCC, 32'h0000_0000, 8'h7F, 2, 0, 10};
        vecs[7] = '{2'b01, 2'b10, 8'hDD, 32'h0000_0001, 8'h01, 8'hEE, 32'h0000_0002, 8'h02, 0, 0, 10};

        // Reset, wipe, then a single ch0 event with latency checks
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd(i, d);
            chk($sformatf("wipe_idx%0d", i), 128'(d), 128'(0));
        end
        chk("wrcnt_after_wipe", 128'(wr_cnt), 128'(0));
        t0 = tb_ts;
        hs_ch0(8'h05, 32'h1000_0040, 8'h03);
        chk("lat_capture_wrcnt", 128'(wr_cnt), 128'(0));
        step();
        chk("lat_write_wrcnt", 128'(wr_cnt), 128'(1));
        exp_e = mk(0, 8'h03, 8'h05, 32'h1000_0040, t0);
        rd(0, d);
        chk("single_entry", 128'(d), 128'(exp_e));
        step();
        chk("rd_hold", 128'(rd_data), 128'(exp_e));

        // Table-driven capture patterns from a fresh reset
        do_reset();
        widx = 0;
        for (int i = 0; i < 8; i++) begin
            t0       = tb_ts;
            id_bus   = {vecs[i].id1, vecs[i].id0};
            addr_bus = {vecs[i].a1, vecs[i].a0};
            len_bus  = {vecs[i].l1, vecs[i].l0};
            valid    = vecs[i].v;
            ready    = vecs[i].r;
            step();
            valid    = '0;
            ready    = '0;
            repeat (3) step();
            chk($sformatf("vec%0d_wrcnt", i), 128'(wr_cnt), 128'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_drop", i), 128'(drop_cnt), 128'(0));
            for (int k = 0; k < vecs[i].n; k++) begin
                ch = (k == 0) ? vecs[i].first : 1 - vecs[i].first;
                if (ch == 0) exp_e = mk(0, vecs[i].l0, vecs[i].id0, vecs[i].a0, t0);
                else         exp_e = mk(1, vecs[i].l1, vecs[i].id1, vecs[i].a1, t0);
                rd(widx, d);
                chk($sformatf("vec%0d_entry%0d", i, k), 128'(d), 128'(exp_e));
                widx++;
            end
        end
        chk("table_afull", 128'(afull), 128'(0));

        // Both channels on three consecutive cycles: two events lost
        do_reset();
        t0 = tb_ts;
        for (int c = 0; c < 3; c++) begin
            id_bus   = {8'(8'h20 + c), 8'(8'h10 + c)};
            addr_bus = {32'h3000_0000, 32'h2000_0000};
            len_bus  = {8'h02, 8'h01};
            valid    = 2'b11;
            ready    = 2'b11;
            step();
        end
        valid = '0;
        ready = '0;
        repeat (4) step();
        chk("burst_wrcnt", 128'(wr_cnt), 128'(4));
        chk("burst_drop", 128'(drop_cnt), 128'(2));
        rd(0, d);
        chk("burst_idx0", 128'(d), 128'(mk(0, 8'h01, 8'h10, 32'h2000_0000, t0)));
        rd(1, d);
        chk("burst_idx1", 128'(d), 128'(mk(1, 8'h02, 8'h20, 32'h3000_0000, t0)));
        rd(2, d);
        chk("burst_idx2", 128'(d), 128'(mk(0, 8'h01, 8'h11, 32'h2000_0000, t0 + 1)));
        rd(3, d);
        chk("burst_idx3", 128'(d), 128'(mk(1, 8'h02, 8'h22, 32'h3000_0000, t0 + 2)));

        // Stop-on-full mode: almost-full, full and drop on the 17th event
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            hs_ch0(8'(k), 32'h4000_0000, 8'h00);
            repeat (2) step();
            if (k == 11) chk("stop_afull_11", 128'(afull), 128'(0));
            if (k == 12) begin
                chk("stop_afull_12", 128'(afull), 128'(1));
                chk("stop_wrcnt_12", 128'(wr_cnt), 128'(12));
            end
            if (k == 15) chk("stop_full_15", 128'(full), 128'(0));
            if (k == 16) begin
                chk("stop_full_16", 128'(full), 128'(1));
                chk("stop_wrcnt_16", 128'(wr_cnt), 128'(16));
                chk("stop_drop_16", 128'(drop_cnt), 128'(0));
            end
            if (k == 17) begin
                chk("stop_drop_17", 128'(drop_cnt), 128'(1));
                chk("stop_wrcnt_17", 128'(wr_cnt), 128'(16));
                chk("stop_full_17", 128'(full), 128'(1));
            end
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_from_full_clearing", 128'(clearing), 128'(1));
        wait_clear_done("clr_from_full_len");
        chk("clr_full_after", 128'(full), 128'(0));
        chk("clr_wrcnt_after", 128'(wr_cnt), 128'(0));
        chk("clr_afull_after", 128'(afull), 128'(0));

        // Ring mode: wrap sets Wrapped, oldest entries overwritten
        mode  = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_clear_done("clr_to_ring_len");
        for (int k = 1; k <= 20; k++) begin
            ts_ev[k] = tb_ts;
            hs_ch0(8'(k), 32'hA000_0000 + 32'(k), 8'(k));
            repeat (2) step();
            if (k == 15) chk("ring_wrapped_15", 128'(wrapped), 128'(0));
            if (k == 16) begin
                chk("ring_wrapped_16", 128'(wrapped), 128'(1));
                chk("ring_full_16", 128'(full), 128'(0));
            end
        end
        chk("ring_wrcnt", 128'(wr_cnt), 128'(16));
        chk("ring_wrapped", 128'(wrapped), 128'(1));
        chk("ring_full", 128'(full), 128'(0));
        chk("ring_afull", 128'(afull), 128'(0));
        chk("ring_drop", 128'(drop_cnt), 128'(0));
        for (int j = 0; j < 4; j++) begin
            rd(j, d);
            chk($sformatf("ring_idx%0d", j), 128'(d),
                128'(mk(0, 8'(17 + j), 8'(17 + j), 32'hA000_0000 + 32'(17 + j), ts_ev[17 + j])));
        end
        rd(4, d);
        chk("ring_idx4", 128'(d), 128'(mk(0, 8'd5, 8'd5, 32'hA000_0005, ts_ev[5])));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
